// File: rtl/nxd_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nxd_timer - KS10 bus-acknowledge watchdog: IO wait/busy, memory NXM and  |
// | an optional fault log (build with NXD_ERRLOG_EN).        Revision: 1.0   |
// +--------------------------------------------------------------------------+
module nxd_timer #(
    parameter int IO_TIMEOUT  = 10,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNTW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:35] cpuADDRO,
    input  logic        cpuREQO,
    input  logic        cpuACKI,
    input  logic        ioCLEAR,
    input  logic        wruDONE,
    input  logic        errCLR,
    output logic        ioWAIT,
    output logic        ioBUSY,
    output logic        nxmERR,
    output logic [0:35] errADDR,
    output logic [0:7]  errCOUNT
);

    localparam int c_BIT_WRU  = 6;
    localparam int c_BIT_VECT = 7;
    localparam int c_BIT_IO   = 8;

    localparam logic [CNTW-1:0] c_IO_LAST  = CNTW'(IO_TIMEOUT - 1);
    localparam logic [CNTW-1:0] c_MEM_LAST = CNTW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_ACKIO1 = 3'd2,
        ST_ACKIO2 = 3'd3,
        ST_ACKWRU = 3'd4,
        ST_ACKVEC = 3'd5,
        ST_NOACK  = 3'd6,
        ST_NXM    = 3'd7
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;
    logic            r_io;
    logic            r_wru;
    logic            r_vect;

    logic w_bus_io;
    logic w_bus_wru;
    logic w_bus_vect;
    logic w_req;
    logic w_last;
    logic w_timeout;

    assign w_bus_io   = cpuADDRO[c_BIT_IO];
    assign w_bus_wru  = cpuADDRO[c_BIT_WRU];
    assign w_bus_vect = cpuADDRO[c_BIT_VECT];
    assign w_req      = cpuREQO & ~cpuACKI;

    assign w_last    = (r_cnt == (r_io ? c_IO_LAST : c_MEM_LAST));
    assign w_timeout = (r_state == ST_COUNT) & ~cpuACKI & w_last;

    assign ioWAIT = w_bus_io & w_req & ((r_state == ST_IDLE) | (r_state == ST_COUNT));
    assign ioBUSY = (w_bus_io & w_req & (r_state == ST_IDLE)) | r_busy;
    assign nxmERR = (r_state == ST_NXM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_io    <= 1'b0;
            r_wru   <= 1'b0;
            r_vect  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ioCLEAR)
                        r_busy <= 1'b0;
                    if (w_req) begin
                        r_io    <= w_bus_io;
                        r_wru   <= w_bus_wru;
                        r_vect  <= w_bus_vect;
                        r_cnt   <= '0;
                        r_state <= ST_COUNT;
                        if (w_bus_io)
                            r_busy <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    // An ack on the final count still wins over the timeout.
                    if (cpuACKI) begin
                        if (!r_io)
                            r_state <= ST_IDLE;
                        else if (r_wru)
                            r_state <= ST_ACKWRU;
                        else if (r_vect)
                            r_state <= ST_ACKVEC;
                        else
                            r_state <= ST_ACKIO1;
                    end else if (w_last) begin
                        r_state <= r_io ? ST_NOACK : ST_NXM;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                ST_ACKIO1: r_state <= ST_ACKIO2;
                ST_ACKIO2: begin
                    if (ioCLEAR) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACKWRU: begin
                    if (wruDONE) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACKVEC: begin
                    if (!w_bus_vect) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_NOACK: begin
                    // Non-WRU timeouts leave busy set as the page-fault flag.
                    if (r_wru) begin
                        r_busy <= 1'b0;
                        if (!w_bus_wru)
                            r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_NXM:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef NXD_ERRLOG_EN
    logic [0:35] r_addr;
    logic [0:35] r_err_addr;
    logic [0:7]  r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req)
                r_addr <= cpuADDRO;
            // A simultaneous clear restarts the count from this fault.
            if (w_timeout) begin
                r_err_addr <= r_addr;
                if (errCLR)
                    r_err_cnt <= 8'd1;
                else if (r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
            end else if (errCLR) begin
                r_err_addr <= '0;
                r_err_cnt  <= '0;
            end
        end
    end

    assign errADDR  = r_err_addr;
    assign errCOUNT = r_err_cnt;
`else
    logic w_unused_log;
    assign w_unused_log = ^{cpuADDRO[0:5], cpuADDRO[9:35], errCLR, w_timeout};

    assign errADDR  = '0;
    assign errCOUNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nxd_timer.sv
`default_nettype none
// tb_nxd_timer - directed and randomized checks of nxd_timer against a
// transaction-level model of the watchdog.
module tb_nxd_timer;

    localparam int IO_L  = 10;
    localparam int MEM_L = 5;
    localparam int CW    = 8;
`ifdef NXD_ERRLOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:35] cpuADDRO = '0;
    logic        cpuREQO = 1'b0;
    logic        cpuACKI = 1'b0;
    logic        ioCLEAR = 1'b0;
    logic        wruDONE = 1'b0;
    logic        errCLR = 1'b0;
    logic        ioWAIT;
    logic        ioBUSY;
    logic        nxmERR;
    logic [0:35] errADDR;
    logic [0:7]  errCOUNT;

    int n_chk  = 0;
    int n_fail = 0;

    nxd_timer #(
        .IO_TIMEOUT (IO_L),
        .MEM_TIMEOUT(MEM_L),
        .CNTW       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpuADDRO(cpuADDRO),
        .cpuREQO (cpuREQO),
        .cpuACKI (cpuACKI),
        .ioCLEAR (ioCLEAR),
        .wruDONE (wruDONE),
        .errCLR  (errCLR),
        .ioWAIT  (ioWAIT),
        .ioBUSY  (ioBUSY),
        .nxmERR  (nxmERR),
        .errADDR (errADDR),
        .errCOUNT(errCOUNT)
    );

    always #5 clk = ~clk;

    function automatic bit f_io(input logic [0:35] a);   return a[8]; endfunction
    function automatic bit f_wru(input logic [0:35] a);  return a[6]; endfunction
    function automatic bit f_vect(input logic [0:35] a); return a[7]; endfunction

    function automatic logic [0:35] mk(input bit io, input bit wru, input bit vect, input logic [35:0] base);
        logic [0:35] a;
        a    = base;
        a[6] = wru;
        a[7] = vect;
        a[8] = io;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: where the current bus cycle stands, the cycle
    // number at which it expires, and the observable busy/log values.
    localparam int MD_FREE    = 0;  // accepting requests
    localparam int MD_TIMING  = 1;  // waiting for ack before deadline
    localparam int MD_SETTLE  = 2;  // one cycle after a plain IO ack
    localparam int MD_WAITCLR = 3;  // IO acked, needs ioCLEAR
    localparam int MD_WAITWRU = 4;  // WRU acked, needs wruDONE
    localparam int MD_WAITVEC = 5;  // vector acked, needs VECT to drop
    localparam int MD_WRUHOLD = 6;  // WRU timed out, needs WRU to drop
    localparam int MD_FAULT   = 7;  // IO page fault, one cycle
    localparam int MD_NXM     = 8;  // memory timeout, one cycle

    int          m_mode = MD_FREE;
    int          m_deadline = 0;
    int          cycn = 0;
    bit          m_io, m_wru, m_vect, m_busy, m_tmo;
    logic [0:35] m_addr = '0;
    logic [0:35] m_eaddr = '0;
    int          m_ecnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  = MD_FREE;
            m_busy  = 1'b0;
            m_eaddr = '0;
            m_ecnt  = 0;
        end else begin
            m_tmo = 1'b0;
            case (m_mode)
                MD_FREE: begin
                    if (cpuREQO && !cpuACKI) begin
                        m_io       = f_io(cpuADDRO);
                        m_wru      = f_wru(cpuADDRO);
                        m_vect     = f_vect(cpuADDRO);
                        m_addr     = cpuADDRO;
                        m_deadline = cycn + (m_io ? IO_L : MEM_L);
                        m_mode     = MD_TIMING;
                        if (m_io) m_busy = 1'b1;
                        else if (ioCLEAR) m_busy = 1'b0;
                    end else if (ioCLEAR) begin
                        m_busy = 1'b0;
                    end
                end
                MD_TIMING: begin
                    if (cpuACKI) begin
                        if (!m_io) m_mode = MD_FREE;
                        else if (m_wru) m_mode = MD_WAITWRU;
                        else if (m_vect) m_mode = MD_WAITVEC;
                        else m_mode = MD_SETTLE;
                    end else if (cycn == m_deadline) begin
                        m_tmo  = 1'b1;
                        m_mode = !m_io ? MD_NXM : (m_wru ? MD_WRUHOLD : MD_FAULT);
                    end
                end
                MD_SETTLE:  m_mode = MD_WAITCLR;
                MD_WAITCLR: if (ioCLEAR) begin m_busy = 1'b0; m_mode = MD_FREE; end
                MD_WAITWRU: if (wruDONE) begin m_busy = 1'b0; m_mode = MD_FREE; end
                MD_WAITVEC: if (!f_vect(cpuADDRO)) begin m_busy = 1'b0; m_mode = MD_FREE; end
                MD_WRUHOLD: begin
                    m_busy = 1'b0;
                    if (!f_wru(cpuADDRO)) m_mode = MD_FREE;
                end
                default: m_mode = MD_FREE;
            endcase
            if (m_tmo) begin
                m_eaddr = m_addr;
                m_ecnt  = errCLR ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
            end else if (errCLR) begin
                m_eaddr = '0;
                m_ecnt  = 0;
            end
            cycn++;
        end
    end

    always @(negedge clk) begin
        logic req_term;
        req_term = f_io(cpuADDRO) & cpuREQO & ~cpuACKI;
        chk("ioWAIT", ioWAIT, req_term & ((m_mode == MD_FREE) || (m_mode == MD_TIMING)));
        chk("ioBUSY", ioBUSY, (req_term & (m_mode == MD_FREE)) | m_busy);
        chk("nxmERR", nxmERR, m_mode == MD_NXM);
        chk("errADDR", errADDR, LOG_EN ? 64'(m_eaddr) : 64'd0);
        chk("errCOUNT", errCOUNT, LOG_EN ? 64'(m_ecnt) : 64'd0);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit req, input bit ack, input logic [0:35] a,
                       input bit clr, input bit wd, input bit ec);
        cpuREQO  = req;
        cpuACKI  = ack;
        cpuADDRO = a;
        ioCLEAR  = clr;
        wruDONE  = wd;
        errCLR   = ec;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            nxt();
            drv(0, 0, '0, 0, 0, 0);
        end
    endtask

    logic [0:35] a_io, a_to, a_wru, a_mem;
    logic [63:0] rr;

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_ioBUSY", ioBUSY, 0);
        chk("rst_nxmERR", nxmERR, 0);
        chk("rst_errCOUNT", errCOUNT, 0);
        chk("rst_errADDR", errADDR, 0);
        nxt();
        nxt();
        rst = 1'b1;
        idle(2);

        // IO request acked at cycle 4; ioCLEAR in ACKIO1 is ignored.
        a_io = mk(1, 0, 0, 36'h0_0001_2345);
        for (int c = 0; c < 4; c++) begin
            nxt(); drv(1, 0, a_io, 0, 0, 0); #2;
            chk("A_ioWAIT_pending", ioWAIT, 1);
        end
        nxt(); drv(1, 1, a_io, 0, 0, 0); #2;
        chk("A_ioWAIT_ack", ioWAIT, 0);
        chk("A_ioBUSY_ack", ioBUSY, 1);
        nxt(); drv(0, 0, a_io, 1, 0, 0); #2;
        nxt(); drv(0, 0, a_io, 0, 0, 0); #2;
        chk("A_ioBUSY_c6", ioBUSY, 1);
        nxt(); drv(0, 0, a_io, 1, 0, 0); #2;
        chk("A_ioBUSY_c7", ioBUSY, 1);
        nxt(); drv(0, 0, a_io, 0, 0, 0); #2;
        chk("A_ioBUSY_c8", ioBUSY, 0);
        idle(2);

        // IO timeout: NOACK at cycle 11, page fault held until ioCLEAR.
        a_to = mk(1, 0, 0, 36'h0_000A_BCDE);
        for (int c = 0; c <= IO_L; c++) begin
            nxt(); drv(1, 0, a_to, 0, 0, 0);
        end
        #2 chk("B_ioWAIT_c10", ioWAIT, 1);
        nxt(); drv(1, 0, a_to, 0, 0, 0); #2;
        chk("B_ioWAIT_noack", ioWAIT, 0);
        chk("B_ioBUSY_noack", ioBUSY, 1);
        chk("B_errCOUNT", errCOUNT, LOG_EN ? 1 : 0);
        chk("B_errADDR", errADDR, LOG_EN ? 64'(a_to) : 64'd0);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("B_ioBUSY_fault", ioBUSY, 1);
        nxt(); drv(0, 0, '0, 1, 0, 0); #2;
        chk("B_ioBUSY_clr", ioBUSY, 1);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("B_ioBUSY_after", ioBUSY, 0);
        idle(2);

        // WRU timeout: busy drops in NOACK, FSM holds until WRU falls.
        a_wru = mk(1, 1, 0, 36'h0_0000_0777);
        for (int c = 0; c <= IO_L; c++) begin
            nxt(); drv(1, 0, a_wru, 0, 0, 0);
        end
        nxt(); drv(0, 0, a_wru, 0, 0, 0); #2;
        chk("C_ioBUSY_noack", ioBUSY, 1);
        chk("C_errCOUNT", errCOUNT, LOG_EN ? 2 : 0);
        nxt(); drv(1, 0, a_wru, 0, 0, 0); #2;
        chk("C_ioBUSY_hold", ioBUSY, 0);
        chk("C_ioWAIT_hold", ioWAIT, 0);
        nxt(); drv(1, 0, a_wru, 0, 0, 0); #2;
        chk("C_ioWAIT_hold2", ioWAIT, 0);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        nxt(); drv(1, 0, mk(1, 0, 0, 36'h1), 0, 0, 0); #2;
        chk("C_idle_again", ioBUSY, 1);
        #1 cpuREQO = 1'b0;
        idle(2);

        // Memory NXM with MEM_TIMEOUT=5: pulse at cycle 6 only.
        a_mem = mk(0, 0, 0, 36'h0_0000_4444);
        for (int c = 0; c <= MEM_L; c++) begin
            nxt(); drv(1, 0, a_mem, 0, 0, 0);
        end
        #2;
        chk("D_nxm_c5", nxmERR, 0);
        chk("D_ioWAIT", ioWAIT, 0);
        chk("D_ioBUSY", ioBUSY, 0);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("D_nxm_c6", nxmERR, 1);
        chk("D_errCOUNT", errCOUNT, LOG_EN ? 3 : 0);
        chk("D_errADDR", errADDR, LOG_EN ? 64'(a_mem) : 64'd0);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("D_nxm_c7", nxmERR, 0);
        idle(2);

        // Memory ack at cycle 3: IDLE again at cycle 4.
        for (int c = 0; c < 3; c++) begin
            nxt(); drv(1, 0, a_mem, 0, 0, 0);
        end
        nxt(); drv(1, 1, a_mem, 0, 0, 0);
        nxt(); drv(1, 0, mk(1, 0, 0, 36'h9), 0, 0, 0); #2;
        chk("E_idle_c4", ioBUSY, 1);
        chk("E_nxm_c4", nxmERR, 0);
        #1 cpuREQO = 1'b0;
        idle(2);

        // Ack on the final count is an ack, not a timeout.
        for (int c = 0; c < MEM_L; c++) begin
            nxt(); drv(1, 0, a_mem, 0, 0, 0);
        end
        nxt(); drv(1, 1, a_mem, 0, 0, 0);
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("F_nxm_coincident", nxmERR, 0);
        chk("F_errCOUNT", errCOUNT, LOG_EN ? 3 : 0);
        idle(2);

        // 256 further timeouts saturate the log count.
        for (int k = 0; k < 256; k++) begin
            for (int c = 0; c <= MEM_L; c++) begin
                nxt(); drv(1, 0, mk(0, 0, 0, 36'(k)), 0, 0, 0);
            end
            nxt(); drv(0, 0, '0, 0, 0, 0);
        end
        #2 chk("G_saturate", errCOUNT, LOG_EN ? 255 : 0);
        idle(1);

        // errCLR on the timeout cycle: log restarts at 1.
        for (int c = 0; c <= MEM_L; c++) begin
            nxt(); drv(1, 0, a_mem, 0, 0, c == MEM_L);
        end
        nxt(); drv(0, 0, '0, 0, 0, 0); #2;
        chk("H_clr_coincident", errCOUNT, LOG_EN ? 1 : 0);
        idle(1);

        // Async reset in the middle of an IO COUNT.
        for (int c = 0; c < 4; c++) begin
            nxt(); drv(1, 0, a_io, 0, 0, 0);
        end
        #2;
        cpuREQO = 1'b0;
        rst     = 1'b0;
        #1;
        chk("I_ioBUSY", ioBUSY, 0);
        chk("I_ioWAIT", ioWAIT, 0);
        chk("I_nxmERR", nxmERR, 0);
        chk("I_errCOUNT", errCOUNT, 0);
        chk("I_errADDR", errADDR, 0);
        nxt();
        rst = 1'b1;
        idle(2);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 5000; i++) begin
            nxt();
            rr = {$urandom, $urandom};
            drv($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
                mk($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, rr[35:0]),
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 24) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nxd_timer.md
# nxd_timer

Parametrised bus-acknowledge watchdog for the KS10 CPU backplane interface. It generalises IO-page-fault timing and adds a memory non-existent-memory (NXM) timeout with a fault-capture log. For IO transactions it times the cycle and provides `ioWAIT` and `ioBUSY` to the microcode. For memory transactions it flags NXM when no acknowledge arrives within a configurable window.

## Interface

Parameters:
- `IO_TIMEOUT`, default 10: cycles in COUNT before an unacknowledged IO cycle is declared NOACK. Legal range is 1..2^`CNTW`.
- `MEM_TIMEOUT`, default 64: cycles in COUNT before an unacknowledged memory cycle is declared NXM. Legal range is 1..2^`CNTW`.
- `CNTW`, default 8: width of the timeout counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, **asynchronous, active-low**.
- `cpuADDRO` in [0:35]: bus address and flags. Decoded with `busIO`, `busWRU` and `busVECT` from `bus.vh`.
- `cpuREQO` in 1: CPU bus request.
- `cpuACKI` in 1: CPU bus acknowledge.
- `ioCLEAR` in 1: microcode CLRIOLAT strobe.
- `wruDONE` in 1: microcode end-of-WRU-sequence strobe.
- `errCLR` in 1: clears the fault log.
- `ioWAIT` out 1: IO wait to the microcode.
- `ioBUSY` out 1: IO busy to the microcode.
- `nxmERR` out 1: one-cycle NXM pulse.
- `errADDR` out [0:35]: address of the most recent timed-out cycle.
- `errCOUNT` out [0:7]: saturating timeout count.

## Operation

States: IDLE, COUNT, ACKIO1, ACKIO2, ACKWRU, ACKVEC, NOACK, NXM.

**IDLE**
- Start condition: `cpuREQO & !cpuACKI`.
- On start, latch `io`=busIO, `wru`=busWRU, `vect`=busVECT and `addr`=cpuADDRO; load `cnt`=0; go to COUNT.
- On start, `busy`<=1 if `io`.
- `ioCLEAR` in IDLE clears `busy`.

**COUNT**
- Limit L is `IO_TIMEOUT` if `io`, otherwise `MEM_TIMEOUT`.
- If `cpuACKI`:
  - memory cycle goes to IDLE;
  - otherwise `wru` goes to ACKWRU, else `vect` goes to ACKVEC, else ACKIO1.
- Else if `cnt`==L-1: go to NOACK if `io`, otherwise NXM.
- Else `cnt`++.
- An ack in the same cycle as `cnt`==L-1 is treated as an ack.

**ACK states**
- ACKIO1 always goes to ACKIO2.
- ACKIO2 waits for `ioCLEAR`, then `busy`<=0 and goes to IDLE.
- ACKWRU waits for `wruDONE`, then `busy`<=0 and goes to IDLE.
- ACKVEC waits for `!busVECT(cpuADDRO)`, then `busy`<=0 and goes to IDLE.

**NOACK**
- If `wru`: `busy`<=0, and stay until `!busWRU(cpuADDRO)`, then go to IDLE.
- Otherwise go to IDLE with `busy` held at 1. This is the page-fault indication; it is cleared by `ioCLEAR` in IDLE.

**NXM**
- `nxmERR`=1 for exactly this one cycle, then go to IDLE.

**Outputs**
- `ioWAIT` = `busIO & cpuREQO & !cpuACKI & (state==IDLE | state==COUNT)`. It is combinational.
- `ioBUSY` = `(busIO & cpuREQO & !cpuACKI & state==IDLE) | busy`.
- `nxmERR` is registered state decode (state==NXM).

**Fault log**
- Updated on entry to NOACK or NXM: `errADDR`<=`addr`; `errCOUNT`<=`errCOUNT`+1, saturating at 255.
- `errCLR` zeroes both.
- `errCLR` in the same cycle as a log update: the update wins, giving `errADDR`=`addr` and `errCOUNT`=1.

## Timing

- Reset (async assert) gives: state=IDLE, `cnt`=0, `busy`=0, `nxmERR`=0, `errADDR`=0, `errCOUNT`=0.
- Outputs after reset: `ioWAIT`/`ioBUSY` follow only the IDLE combinational term.
- Reset deassertion is synchronised externally. Reset mid-cycle abandons the transaction with no log entry.
- Request presented at cycle 0: COUNT is entered at cycle 1.
- With no ack, NOACK/NXM is entered at cycle 1+L. For the defaults: IO at cycle 11, memory at cycle 65.
- `ioWAIT` is high during cycles 0..L while the request is pending. It drops in the same cycle `cpuACKI` rises.
- ACKIO path: `busy` is released no earlier than 3 cycles after the ack and never before `ioCLEAR`.
- A new request is accepted only in IDLE. Requests arriving in other states are ignored until the FSM returns to IDLE.

## Configuration

- `NXD_ERRLOG_EN` defined: the fault log (`errADDR`, `errCOUNT`, `errCLR`) is implemented as specified.
- `NXD_ERRLOG_EN` undefined:
  - no log registers are built;
  - `errADDR`=0 and `errCOUNT`=0 constantly;
  - `errCLR` is ignored.
- All other behaviour is identical in both builds.

## Test plan

- **Default-parameter IO ack.** IO request with ack at cycle 4. Required: `ioWAIT` high for cycles 0..3; ACKIO1 then ACKIO2; `ioBUSY` held until `ioCLEAR`, falling the cycle after it.
- **IO timeout.** IO request, never acked. Required: NOACK at cycle 11; `ioBUSY` remains 1 in IDLE until `ioCLEAR`; `errCOUNT`=1; `errADDR`=request address.
- **WRU timeout.** Same as the IO timeout with busWRU set. Required: `busy` clears in NOACK; the FSM stays in NOACK until busWRU drops, then goes to IDLE.
- **Memory NXM, `MEM_TIMEOUT`=5.** Memory request, never acked. Required: `nxmERR` one-cycle pulse at cycle 6; `ioWAIT`/`ioBUSY` never asserted.
- **Memory ack.** Memory request acked at cycle 3. Required: no `nxmERR`; FSM back in IDLE at cycle 4.
- **Boundary and log cases.**
  - Ack coincident with `cnt`==L-1: treated as an ack.
  - 256 timeouts: `errCOUNT` saturates at 255.
  - `errCLR` coincident with a timeout: `errCOUNT`=1.
  - Async reset asserted mid-COUNT: all outputs return to their reset values immediately.
